// File: rtl/std_pkg.sv
// Shared types and encodings for the iterative restoring divider.
package std_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  localparam int unsigned SIGNED_MODE_UNSIGNED = 0;
  localparam int unsigned SIGNED_MODE_SIGNED   = 1;

endpackage

// File: rtl/std_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, compare, subtract.
module std_div_step #(
  parameter int unsigned width = 32
) (
  input  logic [width-1:0] rem,
  input  logic [width-1:0] quo,
  input  logic [width-1:0] divisor,
  output logic [width-1:0] rem_c,
  output logic [width-1:0] quo_c
);

  logic [width:0]   shifted_c;
  logic [width-1:0] diff_c;
  logic             ge_c;

  // Partial remainder is below the divisor, so a successful subtract always fits in width bits.
  always_comb begin
    shifted_c = {rem, quo[width-1]};
    ge_c      = (shifted_c >= {1'b0, divisor});
    diff_c    = shifted_c[width-1:0] - divisor;
    rem_c     = ge_c ? diff_c : shifted_c[width-1:0];
    quo_c     = {quo[width-2:0], ge_c};
  end

endmodule

// File: rtl/std_div_pipe.sv
// Iterative divider: one quotient bit per cycle, signed fix-up around an unsigned core.
module std_div_pipe
  import std_pkg::*;
#(
  parameter int unsigned width       = 32,
  parameter int unsigned signed_mode = SIGNED_MODE_UNSIGNED
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [width-1:0] left,
  input  logic [width-1:0] right,
  input  logic             valid,
  output logic             ready,
  output logic             busy,
  output logic [width-1:0] out_quotient,
  output logic [width-1:0] out_remainder,
  output logic             div_by_zero
);

  localparam int unsigned CNT_W     = $clog2(width + 1);
  localparam bit          IS_SIGNED = (signed_mode == SIGNED_MODE_SIGNED);

  div_state_e state, state_nxt;

  logic             accept_c;
  logic             last_step_c;
  logic             left_neg_c;
  logic             right_neg_c;
  logic [width-1:0] left_abs_c;
  logic [width-1:0] right_abs_c;
  logic [width-1:0] step_rem_c;
  logic [width-1:0] step_quo_c;
  logic [width-1:0] fin_quo_c;
  logic [width-1:0] fin_rem_c;

  logic [width-1:0] quo_q;
  logic [width-1:0] rem_q;
  logic [width-1:0] dvs_q;
  logic [width-1:0] dvd_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic             zero_q;
  logic [CNT_W-1:0] cnt_q;

  assign accept_c    = valid && ((state == ST_IDLE) || (state == ST_DONE));
  assign last_step_c = (state == ST_RUN) && (cnt_q == CNT_W'(width - 1));

  // Operand magnitudes; the most-negative value maps to its own unsigned pattern, which is exact.
  always_comb begin
    left_neg_c  = IS_SIGNED && left[width-1];
    right_neg_c = IS_SIGNED && right[width-1];
    left_abs_c  = left_neg_c  ? (~left  + width'(1)) : left;
    right_abs_c = right_neg_c ? (~right + width'(1)) : right;
  end

  std_div_step #(
    .width (width)
  ) u_step (
    .rem     (rem_q),
    .quo     (quo_q),
    .divisor (dvs_q),
    .rem_c   (step_rem_c),
    .quo_c   (step_quo_c)
  );

  // Final result from the last iteration; zero divisor overrides with the defined pattern.
  always_comb begin
    fin_quo_c = neg_quo_q ? (~step_quo_c + width'(1)) : step_quo_c;
    fin_rem_c = neg_rem_q ? (~step_rem_c + width'(1)) : step_rem_c;
    if (zero_q) begin
      fin_quo_c = '1;
      fin_rem_c = dvd_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (valid) state_nxt = ST_RUN;
      ST_RUN:  if (last_step_c) state_nxt = ST_DONE;
      ST_DONE: state_nxt = valid ? ST_RUN : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Iteration registers: load on accept, advance one bit per RUN cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      dvd_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      zero_q    <= 1'b0;
      cnt_q     <= '0;
    end else if (accept_c) begin
      quo_q     <= left_abs_c;
      rem_q     <= '0;
      dvs_q     <= right_abs_c;
      dvd_q     <= left;
      neg_quo_q <= left_neg_c ^ right_neg_c;
      neg_rem_q <= left_neg_c;
      zero_q    <= (right == '0);
      cnt_q     <= '0;
    end else if (state == ST_RUN) begin
      quo_q <= step_quo_c;
      rem_q <= step_rem_c;
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Results change only when an operation completes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready         <= 1'b0;
      busy          <= 1'b0;
      out_quotient  <= '0;
      out_remainder <= '0;
      div_by_zero   <= 1'b0;
    end else begin
      ready <= last_step_c;
      busy  <= (state_nxt == ST_RUN);
      if (last_step_c) begin
        out_quotient  <= fin_quo_c;
        out_remainder <= fin_rem_c;
        div_by_zero   <= zero_q;
      end
    end
  end

endmodule

// File: tb/tb_std_div_pipe.sv
// Bench for std_div_pipe: unsigned and signed instances against an arithmetic reference.
module tb_std_div_pipe;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] left;
  logic [W-1:0] right;
  logic         valid;

  logic         ready_u, busy_u, dbz_u;
  logic [W-1:0] quo_u, rem_u;
  logic         ready_s, busy_s, dbz_s;
  logic [W-1:0] quo_s, rem_s;

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0] prev_qu = '0, prev_ru = '0, prev_qs = '0, prev_rs = '0;
  logic         prev_zu = 1'b0, prev_zs = 1'b0;

  always #5 clk = ~clk;

  std_div_pipe #(.width(W), .signed_mode(0)) dut_u (
    .clk(clk), .reset_n(reset_n), .left(left), .right(right), .valid(valid),
    .ready(ready_u), .busy(busy_u), .out_quotient(quo_u), .out_remainder(rem_u),
    .div_by_zero(dbz_u)
  );

  std_div_pipe #(.width(W), .signed_mode(1)) dut_s (
    .clk(clk), .reset_n(reset_n), .left(left), .right(right), .valid(valid),
    .ready(ready_s), .busy(busy_s), .out_quotient(quo_s), .out_remainder(rem_s),
    .div_by_zero(dbz_s)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Reference from plain integer arithmetic; SV integer / and % truncate toward zero.
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit sgn,
                                  output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
    int sa, sb;
    if (b == '0) begin
      q = '1; r = a; z = 1'b1;
    end else if (!sgn) begin
      q = a / b; r = a % b; z = 1'b0;
    end else begin
      sa = int'($signed(a));
      sb = int'($signed(b));
      q = W'(sa / sb); r = W'(sa % sb); z = 1'b0;
    end
  endfunction

  task automatic chk_held(input string tag);
    chk({tag, "_qu"}, 64'(quo_u), 64'(prev_qu));
    chk({tag, "_ru"}, 64'(rem_u), 64'(prev_ru));
    chk({tag, "_qs"}, 64'(quo_s), 64'(prev_qs));
    chk({tag, "_rs"}, 64'(rem_s), 64'(prev_rs));
    chk({tag, "_z"},  64'({dbz_u, dbz_s}), 64'({prev_zu, prev_zs}));
  endtask

  // Entered and left at a negedge. mode 0: quiet, 1: random junk during RUN, 2: valid held high.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int mode);
    logic [W-1:0] equ, eru, eqs, ers;
    logic         ezu, ezs;
    ref_div(a, b, 1'b0, equ, eru, ezu);
    ref_div(a, b, 1'b1, eqs, ers, ezs);
    left = a; right = b; valid = 1'b1;
    @(posedge clk); #1;
    if (mode == 0) valid = 1'b0;
    if (mode == 1) begin
      left = W'($urandom); right = W'($urandom); valid = 1'(~$urandom);
    end
    for (int k = 1; k <= int'(W); k++) begin
      @(negedge clk);
      chk("busy_run", 64'({busy_u, busy_s}), 64'(2'b11));
      chk("ready_run", 64'({ready_u, ready_s}), 64'(2'b00));
      if (k == int'(W / 2)) chk_held("held_run");
      if (mode == 1) begin
        left = W'($urandom); right = W'($urandom);
        valid = (k < int'(W)) ? 1'($urandom) : 1'b0;
      end
    end
    @(negedge clk);
    chk("ready_done", 64'({ready_u, ready_s}), 64'(2'b11));
    chk("busy_done", 64'({busy_u, busy_s}), 64'(2'b00));
    chk("quo_u", 64'(quo_u), 64'(equ));
    chk("rem_u", 64'(rem_u), 64'(eru));
    chk("dbz_u", 64'(dbz_u), 64'(ezu));
    chk("quo_s", 64'(quo_s), 64'(eqs));
    chk("rem_s", 64'(rem_s), 64'(ers));
    chk("dbz_s", 64'(dbz_s), 64'(ezs));
    prev_qu = equ; prev_ru = eru; prev_zu = ezu;
    prev_qs = eqs; prev_rs = ers; prev_zs = ezs;
  endtask

  task automatic idle(input int n);
    valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("ready_idle", 64'({ready_u, ready_s}), 64'(2'b00));
      chk("busy_idle", 64'({busy_u, busy_s}), 64'(2'b00));
      chk_held("held_idle");
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, 64'({ready_u, busy_u, dbz_u, ready_s, busy_s, dbz_s}), 64'(0));
    chk({tag, "_res"}, 64'({quo_u, rem_u, quo_s, rem_s}), 64'(0));
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    reset_n = 1'b1; valid = 1'b0; left = '0; right = '0;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset_n = 1'b1;

    run_op(8'd100, 8'd7, 0);
    idle(2);
    run_op(8'd55, 8'd0, 0);
    idle(1);
    run_op(8'hF9, 8'd2, 0);
    run_op(8'h80, 8'hFF, 0);
    idle(1);
    run_op(8'd200, 8'd10, 2);
    run_op(8'd9, 8'd3, 0);
    idle(2);
    run_op(8'd100, 8'd7, 1);
    idle(1);

    // Reset in cycle 4 of an operation: outputs clear at once and no ready follows.
    left = 8'd77; right = 8'd5; valid = 1'b1;
    @(posedge clk); #1 valid = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #1 reset_n = 1'b0;
    #1 chk_zero("reset_mid");
    prev_qu = '0; prev_ru = '0; prev_qs = '0; prev_rs = '0; prev_zu = 1'b0; prev_zs = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk_zero("reset_hold");
    end
    reset_n = 1'b1;
    run_op(8'd250, 8'd13, 0);
    idle(1);

    for (int i = 0; i < 60; i++) begin
      ra = W'($urandom);
      rb = (($urandom % 8) == 0) ? '0 : W'($urandom);
      if (($urandom % 10) == 0) begin ra = 8'h80; rb = 8'hFF; end
      run_op(ra, rb, int'($urandom % 3));
      if (($urandom % 2) == 0) idle(int'($urandom % 3) + 1);
    end
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
